// File: rtl/parking_gate_ctrl.sv
// Parking gate lane controller: debounces entry/exit presence sensors and sequences
// request pulses, barrier timing and reject lamp against the occupancy FSM.
module parking_gate_ctrl #(
    parameter int OPEN_CYCLES = 8,
    parameter int DEBOUNCE    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       car_at_entry,
    input  logic       car_at_exit,
    input  logic [1:0] exit_slot_sel,
    input  logic       is_full,
    input  logic [3:0] spots,
    output logic       entry_signal,
    output logic       exit_signal,
    output logic [1:0] exit_slot,
    output logic       barrier_up,
    output logic       reject,
    output logic       busy
);

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE - 1);
    localparam logic [7:0] OPEN_LAST = 8'(OPEN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ENT_REQ,
        ENT_OPEN,
        ENT_WAIT,
        EXT_REQ,
        EXT_OPEN,
        EXT_WAIT,
        REJ
    } state_t;

    // Lane 0 = entry, lane 1 = exit.
    logic [1:0] raw;
    logic [1:0] deb_level;

    assign raw = {car_at_exit, car_at_entry};

    // Level flips only after DEBOUNCE consecutive contrary samples; an agreeing sample restarts.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic       level_reg;
            logic [3:0] cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    level_reg <= 1'b0;
                    cnt_reg   <= 4'd0;
                end else if (raw[gi] == level_reg) begin
                    cnt_reg <= 4'd0;
                end else if (cnt_reg == DEB_LAST) begin
                    level_reg <= raw[gi];
                    cnt_reg   <= 4'd0;
                end else begin
                    cnt_reg <= cnt_reg + 4'd1;
                end
            end

            assign deb_level[gi] = level_reg;
        end
    endgenerate

    logic entry_level;
    logic exit_level;

    assign entry_level = deb_level[0];
    assign exit_level  = deb_level[1];

    state_t     state_reg;
    logic       rej_exit_reg;
    logic [7:0] open_cnt_reg;
    logic [1:0] exit_slot_reg;
    logic       entry_signal_reg;
    logic       exit_signal_reg;
    logic       barrier_up_reg;
    logic       reject_reg;
    logic       busy_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            rej_exit_reg     <= 1'b0;
            open_cnt_reg     <= 8'd0;
            exit_slot_reg    <= 2'd0;
            entry_signal_reg <= 1'b0;
            exit_signal_reg  <= 1'b0;
            barrier_up_reg   <= 1'b0;
            reject_reg       <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            entry_signal_reg <= 1'b0;
            exit_signal_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // Exit lane has priority: it frees a slot rather than consuming one.
                    if (exit_level) begin
                        busy_reg <= 1'b1;
                        if (spots[exit_slot_sel]) begin
                            state_reg       <= EXT_REQ;
                            exit_signal_reg <= 1'b1;
                            exit_slot_reg   <= exit_slot_sel;
                        end else begin
                            state_reg    <= REJ;
                            rej_exit_reg <= 1'b1;
                            reject_reg   <= 1'b1;
                            open_cnt_reg <= OPEN_LAST;
                        end
                    end else if (entry_level) begin
                        busy_reg <= 1'b1;
                        if (!is_full) begin
                            state_reg        <= ENT_REQ;
                            entry_signal_reg <= 1'b1;
                        end else begin
                            state_reg    <= REJ;
                            rej_exit_reg <= 1'b0;
                            reject_reg   <= 1'b1;
                            open_cnt_reg <= OPEN_LAST;
                        end
                    end
                end
                ENT_REQ, EXT_REQ: begin
                    state_reg      <= (state_reg == ENT_REQ) ? ENT_OPEN : EXT_OPEN;
                    barrier_up_reg <= 1'b1;
                    open_cnt_reg   <= OPEN_LAST;
                end
                ENT_OPEN, EXT_OPEN: begin
                    if (open_cnt_reg == 8'd0) begin
                        state_reg      <= (state_reg == ENT_OPEN) ? ENT_WAIT : EXT_WAIT;
                        barrier_up_reg <= 1'b0;
                    end else begin
                        open_cnt_reg <= open_cnt_reg - 8'd1;
                    end
                end
                REJ: begin
                    if (open_cnt_reg == 8'd0) begin
                        state_reg  <= rej_exit_reg ? EXT_WAIT : ENT_WAIT;
                        reject_reg <= 1'b0;
                    end else begin
                        open_cnt_reg <= open_cnt_reg - 8'd1;
                    end
                end
                ENT_WAIT: begin
                    if (!entry_level) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                EXT_WAIT: begin
                    if (!exit_level) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    barrier_up_reg <= 1'b0;
                    reject_reg     <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign entry_signal = entry_signal_reg;
    assign exit_signal  = exit_signal_reg;
    assign exit_slot    = exit_slot_reg;
    assign barrier_up   = barrier_up_reg;
    assign reject       = reject_reg;
    assign busy         = busy_reg;

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter OPEN_CYCLES, default 8: cycles the barrier (or reject lamp) stays asserted per event; legal range 1..255.
REQ-002 Parameter DEBOUNCE, default 3: consecutive sampled-high/low cycles needed to change a sensor's debounced level; legal range 1..15.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 car_at_entry  input  1  raw entry-lane presence sensor, asynchronous to nothing (already in clk domain), may bounce.
REQ-006 car_at_exit  input  1  raw exit-lane presence sensor, same properties.
REQ-007 exit_slot_sel  input  2  slot index presented by the exiting driver's ticket reader, valid whenever car_at_exit is high.
REQ-008 is_full  input  1  occupancy FSM full flag.
REQ-009 spots  input  4  occupancy FSM slot map; bit k = 1 means slot k occupied.
REQ-010 entry_signal  output  1  one-cycle entry request to the occupancy FSM.
REQ-011 exit_signal  output  1  one-cycle exit request to the occupancy FSM.
REQ-012 exit_slot  output  2  slot index accompanying exit_signal; held until next exit request.
REQ-013 barrier_up  output  1  gate barrier drive, 1 = raised.
REQ-014 reject  output  1  reject lamp, 1 = request refused.
REQ-015 busy  output  1  1 whenever the controller is not in IDLE.

Function
REQ-016 Each sensor SHALL have its own debouncer: debounced level flips only after DEBOUNCE consecutive edges sampling the opposite raw value; any contrary sample restarts the count.
REQ-017 States SHALL be IDLE, ENT_REQ, ENT_OPEN, ENT_WAIT, EXT_REQ, EXT_OPEN, EXT_WAIT, REJ; a side register records which lane (entry/exit) REJ serves.
REQ-018 IDLE: debounced exit high -> EXT_REQ if spots[exit_slot_sel]=1, else REJ(exit); else debounced entry high -> ENT_REQ if is_full=0, else REJ(entry); else stay.
REQ-019 Simultaneous debounced entry and exit in IDLE SHALL serve exit first; entry is served on return to IDLE if still present.
REQ-020 exit_slot_sel SHALL be captured into exit_slot on the IDLE->EXT_REQ edge; exit_slot holds that value until the next such capture.
REQ-021 ENT_REQ / EXT_REQ SHALL last exactly one cycle with entry_signal / exit_signal = 1, then go to ENT_OPEN / EXT_OPEN.
REQ-022 ENT_OPEN / EXT_OPEN SHALL assert barrier_up for exactly OPEN_CYCLES cycles (8-bit down-counter), then go to ENT_WAIT / EXT_WAIT.
REQ-023 ENT_WAIT / EXT_WAIT SHALL hold barrier_up=0 and return to IDLE on the first edge at which that lane's debounced level is 0.
REQ-024 REJ SHALL assert reject for exactly OPEN_CYCLES cycles with barrier_up=0 and no request pulse, then go to the recorded lane's WAIT state.
REQ-025 Sensor activity on the non-served lane SHALL be ignored (not queued) outside IDLE, except through its debounced level, which continues tracking.
REQ-026 entry_signal and exit_signal SHALL never be high in the same cycle; at most one request pulse per served car.
REQ-027 Latency: request pulse SHALL be high in the cycle immediately after the edge on which the debounced level first reads 1 while in IDLE.
REQ-028 All outputs SHALL be registered; busy = (state != IDLE).

Reset
REQ-029 While reset=1: state=IDLE, debounced levels=0, debounce and open counters=0, exit_slot=0, all 1-bit outputs=0, effective immediately without a clock.
REQ-030 Reset asserted mid-operation SHALL drop barrier_up/reject at once and discard any in-progress request; a car still present is re-served after release plus DEBOUNCE cycles.

Verification (bench uses OPEN_CYCLES=4, DEBOUNCE=2)
REQ-031 Entry: is_full=0, car_at_entry high 10 cycles -> entry_signal one pulse 1 cycle after 2nd sample; barrier_up 4 cycles; IDLE 2 cycles after sensor drops.
REQ-032 Exit: spots=0101, exit_slot_sel=2, car_at_exit high -> exit_signal one pulse, exit_slot=2 held afterward, barrier_up 4 cycles.
REQ-033 Reject: is_full=1 with entry car, then spots=0000 with exit car on slot 3 -> reject 4 cycles each, no request pulses, barrier_up stays 0.
REQ-034 Bounce/simultaneous: entry raw 1,0,1,1 -> single pulse only after the final 1,1; entry and exit debounced on same edge -> exit_signal first, entry_signal after exit lane clears.
REQ-035 Reset mid-ENT_OPEN -> barrier_up=0 asynchronously, exit_slot=0; after release with car still present, exactly one new entry_signal.
